wb_timer: RTL



---
 rtl/wb_timer_pkg.sv | 22 ++
 rtl/wb_timer_if.sv | 25 ++
 rtl/wb_timer_slave_if.sv | 63 ++++++
 rtl/wb_timer.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/wb_timer_pkg.sv
// Shared definitions for the wb_timer peripheral: bus widths, register
// offsets, CTRL/STATUS bit positions and the full-word byte-select value.
package wb_timer_pkg;

  localparam int SEL_WIDTH = 4;
  localparam int ADR_WIDTH = 32;
  localparam int DAT_WIDTH = 32;

  localparam logic [1:0] TIMER_CTRL   = 2'd0;
  localparam logic [1:0] TIMER_LOAD   = 2'd1;
  localparam logic [1:0] TIMER_COUNT  = 2'd2;
  localparam logic [1:0] TIMER_STATUS = 2'd3;

  localparam int CTRL_EN_BIT     = 0;
  localparam int CTRL_AR_BIT     = 1;
  localparam int CTRL_IRQ_EN_BIT = 2;
  localparam int CTRL_PS_LSB     = 8;
  localparam int STATUS_EXP_BIT  = 0;

  localparam logic [SEL_WIDTH-1:0] SEL_FULL = 4'b1111;

endpackage

// File: rtl/wb_timer_if.sv
// Wishbone classic slave-side signal bundle for the timer slot. Signal
// suffixes are from the slave's point of view.
interface wb_timer_if;

  logic                                 timer_stb_i;
  logic                                 timer_cyc_i;
  logic                                 timer_we_i;
  logic [wb_timer_pkg::SEL_WIDTH-1:0]   timer_sel_i;
  logic [wb_timer_pkg::ADR_WIDTH-1:0]   timer_adr_i;
  logic [wb_timer_pkg::DAT_WIDTH-1:0]   timer_dat_i;
  logic [wb_timer_pkg::DAT_WIDTH-1:0]   timer_dat_o;
  logic                                 timer_ack_o;
  logic                                 timer_err_o;

  modport master (
    output timer_stb_i, timer_cyc_i, timer_we_i, timer_sel_i, timer_adr_i, timer_dat_i,
    input  timer_dat_o, timer_ack_o, timer_err_o
  );

  modport slave (
    input  timer_stb_i, timer_cyc_i, timer_we_i, timer_sel_i, timer_adr_i, timer_dat_i,
    output timer_dat_o, timer_ack_o, timer_err_o
  );

endinterface

// File: rtl/wb_timer_slave_if.sv
// wb_slave_if: reusable Wishbone classic slave front end. Accepts one access
// per termination, registers ack/err one cycle later for one cycle, registers
// read data with the ack, and hands the register file a one-cycle
// write/read strobe with the decoded word index. Partial-word accesses
// terminate with err and produce no strobe.
module wb_slave_if
  import wb_timer_pkg::*;
(
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 cyc_i,
  input  logic                 stb_i,
  input  logic                 we_i,
  input  logic [SEL_WIDTH-1:0] sel_i,
  input  logic [1:0]           adr_i,
  input  logic [DAT_WIDTH-1:0] rdata_i,
  output logic                 ack_o,
  output logic                 err_o,
  output logic [DAT_WIDTH-1:0] dat_o,
  output logic                 wr_stb_o,
  output logic                 rd_stb_o,
  output logic [1:0]           idx_o
);

  logic                 ack_q, ack_d;
  logic                 err_q, err_d;
  logic [DAT_WIDTH-1:0] dat_q, dat_d;
  logic                 accept;
  logic                 word;

  // A new access is taken only when the previous termination has retired,
  // so a held strobe gives one termination every other cycle.
  assign accept = cyc_i & stb_i & ~ack_q & ~err_q;
  assign word   = (sel_i == SEL_FULL);

  // Termination and read-data next state; dat holds unless a read is taken.
  always_comb begin
    ack_d    = accept & word;
    err_d    = accept & ~word;
    wr_stb_o = accept & word & we_i;
    rd_stb_o = accept & word & ~we_i;
    dat_d    = (accept & word & ~we_i) ? rdata_i : dat_q;
  end

  // Termination registers; reset drops any pending ack/err.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ack_q <= 1'b0;
      err_q <= 1'b0;
      dat_q <= '0;
    end else begin
      ack_q <= ack_d;
      err_q <= err_d;
      dat_q <= dat_d;
    end
  end

  assign ack_o = ack_q;
  assign err_o = err_q;
  assign dat_o = dat_q;
  assign idx_o = adr_i;

endmodule

// File: rtl/wb_timer.sv
// wb_timer: Wishbone classic timer peripheral. Prescaled down-counter with
// one-shot or auto-reload mode and a sticky, write-1-to-clear expiry flag.
// Optional feature macro WB_TIMER_IRQ_EN adds CTRL[2] IRQ_EN and a
// registered level interrupt irq_o = EXPIRED & IRQ_EN.
module wb_timer
  import wb_timer_pkg::*;
#(
  parameter int PRESCALE_WIDTH = 8,
  parameter int COUNT_WIDTH    = 32
) (
  input  logic        clk_i,
  input  logic        rst_i,
  wb_timer_if.slave   bus
`ifdef WB_TIMER_IRQ_EN
  ,
  output logic        irq_o
`endif
);

  localparam logic [COUNT_WIDTH-1:0]    COUNT_ONE = 1;
  localparam logic [PRESCALE_WIDTH-1:0] PRESC_ONE = 1;

  logic                      wr_stb;
  logic                      rd_stb_unused;
  logic [1:0]                idx;
  logic [DAT_WIDTH-1:0]      wdata;
  logic [DAT_WIDTH-1:0]      rdata;
  logic                      unused_adr_bits;

  logic                      en_q, en_d;
  logic                      ar_q, ar_d;
  logic [PRESCALE_WIDTH-1:0] ps_q, ps_d;
  logic [COUNT_WIDTH-1:0]    load_q, load_d;
  logic [COUNT_WIDTH-1:0]    count_q, count_d;
  logic                      exp_q, exp_d;
  logic [PRESCALE_WIDTH-1:0] presc_q, presc_d;
  logic                      tick;
  logic                      expire_now;
`ifdef WB_TIMER_IRQ_EN
  logic                      ie_q, ie_d;
  logic                      irq_q, irq_d;
`endif

  assign unused_adr_bits = ^{bus.timer_adr_i[ADR_WIDTH-1:4], bus.timer_adr_i[1:0]};
  assign wdata           = bus.timer_dat_i;

  wb_slave_if u_slave (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .cyc_i    (bus.timer_cyc_i),
    .stb_i    (bus.timer_stb_i),
    .we_i     (bus.timer_we_i),
    .sel_i    (bus.timer_sel_i),
    .adr_i    (bus.timer_adr_i[3:2]),
    .rdata_i  (rdata),
    .ack_o    (bus.timer_ack_o),
    .err_o    (bus.timer_err_o),
    .dat_o    (bus.timer_dat_o),
    .wr_stb_o (wr_stb),
    .rd_stb_o (rd_stb_unused),
    .idx_o    (idx)
  );

  // The prescaler wraps on reaching PRESCALE; that wrap is the count tick.
  assign tick       = en_q & (presc_q == ps_q);
  assign expire_now = tick & (count_q == '0);

  // Register read mux; unused bits read as zero.
  always_comb begin
    rdata = '0;
    case (idx)
      TIMER_CTRL: begin
        rdata[CTRL_EN_BIT] = en_q;
        rdata[CTRL_AR_BIT] = ar_q;
`ifdef WB_TIMER_IRQ_EN
        rdata[CTRL_IRQ_EN_BIT] = ie_q;
`endif
        rdata[CTRL_PS_LSB +: PRESCALE_WIDTH] = ps_q;
      end
      TIMER_LOAD:   rdata[COUNT_WIDTH-1:0] = load_q;
      TIMER_COUNT:  rdata[COUNT_WIDTH-1:0] = count_q;
      TIMER_STATUS: rdata[STATUS_EXP_BIT]  = exp_q;
      default:      rdata = '0;
    endcase
  end

  // Timer next state: tick effects first, then bus writes override them,
  // except that an expiry in the same cycle wins over a STATUS clear.
  always_comb begin
    en_d    = en_q;
    ar_d    = ar_q;
    ps_d    = ps_q;
    load_d  = load_q;
    count_d = count_q;
    exp_d   = exp_q;
    presc_d = presc_q;
`ifdef WB_TIMER_IRQ_EN
    ie_d    = ie_q;
    irq_d   = exp_q & ie_q;
`endif

    if (en_q) begin
      presc_d = tick ? '0 : presc_q + PRESC_ONE;
    end

    if (tick) begin
      if (count_q != '0) begin
        count_d = count_q - COUNT_ONE;
      end else begin
        exp_d = 1'b1;
        if (ar_q) begin
          count_d = load_q;
        end else begin
          en_d = 1'b0;
        end
      end
    end

    if (wr_stb) begin
      case (idx)
        TIMER_CTRL: begin
          // Enabling restarts the prescale period from the write edge.
          if (!en_q && wdata[CTRL_EN_BIT]) begin
            presc_d = '0;
          end
          en_d = wdata[CTRL_EN_BIT];
          ar_d = wdata[CTRL_AR_BIT];
          ps_d = wdata[CTRL_PS_LSB +: PRESCALE_WIDTH];
`ifdef WB_TIMER_IRQ_EN
          ie_d = wdata[CTRL_IRQ_EN_BIT];
`endif
        end
        TIMER_LOAD:  load_d  = wdata[COUNT_WIDTH-1:0];
        TIMER_COUNT: count_d = wdata[COUNT_WIDTH-1:0];
        TIMER_STATUS: begin
          if (wdata[STATUS_EXP_BIT] && !expire_now) begin
            exp_d = 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  // Timer state registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      en_q    <= 1'b0;
      ar_q    <= 1'b0;
      ps_q    <= '0;
      load_q  <= '0;
      count_q <= '0;
      exp_q   <= 1'b0;
      presc_q <= '0;
`ifdef WB_TIMER_IRQ_EN
      ie_q    <= 1'b0;
      irq_q   <= 1'b0;
`endif
    end else begin
      en_q    <= en_d;
      ar_q    <= ar_d;
      ps_q    <= ps_d;
      load_q  <= load_d;
      count_q <= count_d;
      exp_q   <= exp_d;
      presc_q <= presc_d;
`ifdef WB_TIMER_IRQ_EN
      ie_q    <= ie_d;
      irq_q   <= irq_d;
`endif
    end
  end

`ifdef WB_TIMER_IRQ_EN
  assign irq_o = irq_q;
`endif

endmodule
